// File: rtl/add_sub_accumulator_pkg.sv
// Shared definitions for the add/sub accumulator: default sizes, FSM state
// encodings and the signed-overflow helper used by the accumulator stage.
package add_sub_accumulator_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  // Two's-complement overflow: both addends share a sign and the sum differs from it.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_sub_accumulator_datapath.sv
// Combinational add/sub datapath: sum = a + (cin ? ~b : b) + cin.
// cin doubles as the subtract select, so cout reads as "no borrow" on subtract.
module add_sub_4bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             b_eff_msb
);

  logic [WIDTH-1:0] b_eff_s;

  assign b_eff_s     = cin ? ~b : b;
  assign b_eff_msb   = b_eff_s[WIDTH-1];
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/add_sub_accumulator.sv
// Sequential accumulator around the add/sub datapath. Each accepted operand is
// folded into the running accumulator and the result is offered downstream
// over valid/ready. FSM: IDLE -> EXEC -> RESULT -> IDLE.
// Optional feature: define ADD_SUB_SAT_EN for unsigned saturation of the
// accumulator (carry_out/ovf still report the raw datapath result).
module add_sub_accumulator
  import add_sub_accumulator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic             op_sub,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH:0]   sum_f,
  output logic             carry_out,
  output logic             ovf,
  output logic [CNT_W-1:0] op_count
);

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] operand_r;
  logic             sub_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH:0]   sum_f_r;
  logic             carry_r;
  logic             ovf_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] dp_sum_s;
  logic             dp_cout_s;
  logic             dp_b_msb_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             accept_s;

  // Datapath sees the live accumulator and the operand captured at accept.
  add_sub_4bit #(.WIDTH(WIDTH)) u_datapath (
    .a         (acc_r),
    .b         (operand_r),
    .cin       (sub_r),
    .sum       (dp_sum_s),
    .cout      (dp_cout_s),
    .b_eff_msb (dp_b_msb_s)
  );

  // clear wins over in_valid in IDLE; nothing is accepted while reset is held.
  assign in_ready  = (state_r == ST_IDLE) && !clear && !rst;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_r == ST_RESULT);
  assign acc_out   = acc_r;
  assign sum_f     = sum_f_r;
  assign carry_out = carry_r;
  assign ovf       = ovf_r;
  assign op_count  = count_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: one EXEC cycle, then hold RESULT until downstream takes it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_EXEC;
        else          state_next_s = ST_IDLE;
      end
      ST_EXEC: begin
        state_next_s = ST_RESULT;
      end
      ST_RESULT: begin
        if (out_ready) state_next_s = ST_IDLE;
        else           state_next_s = ST_RESULT;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Accumulator update value: raw datapath sum, optionally clamped to the unsigned range.
  always_comb begin
    acc_next_s = dp_sum_s;
`ifdef ADD_SUB_SAT_EN
    if (!sub_r && dp_cout_s) begin
      acc_next_s = {WIDTH{1'b1}};
    end else if (sub_r && !dp_cout_s) begin
      acc_next_s = {WIDTH{1'b0}};
    end else begin
      acc_next_s = dp_sum_s;
    end
`endif
  end

  // Operand capture, clear, and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand_r <= {WIDTH{1'b0}};
      sub_r     <= 1'b0;
      acc_r     <= {WIDTH{1'b0}};
      sum_f_r   <= {(WIDTH+1){1'b0}};
      carry_r   <= 1'b0;
      ovf_r     <= 1'b0;
      count_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clear) begin
            acc_r   <= {WIDTH{1'b0}};
            sum_f_r <= {(WIDTH+1){1'b0}};
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            count_r <= {CNT_W{1'b0}};
          end else if (accept_s) begin
            operand_r <= operand;
            sub_r     <= op_sub;
          end
        end
        ST_EXEC: begin
          acc_r   <= acc_next_s;
          carry_r <= dp_cout_s;
          sum_f_r <= {dp_cout_s, acc_next_s};
          ovf_r   <= signed_ovf(acc_r[WIDTH-1], dp_b_msb_s, dp_sum_s[WIDTH-1]);
          count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_accumulator.sv
// Scoreboard bench for add_sub_accumulator: a predictor pushes expected results
// at each accept, a monitor pops and compares whenever a result is presented.
module tb_add_sub_accumulator;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, op_sub, clear, out_valid, out_ready;
  logic       carry_out, ovf;
  logic [3:0] operand, acc_out;
  logic [4:0] sum_f;
  logic [7:0] op_count;

  typedef struct {
    int acc;
    int c;
    int sumf;
    int ovf;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state
  int   m_acc, m_c, m_sumf, m_ovf, m_cnt, age;
  bit   busy;

  add_sub_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand(operand), .op_sub(op_sub), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .sum_f(sum_f), .carry_out(carry_out), .ovf(ovf), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t predict(input int a, input int b, input bit sub, input int cnt);
    exp_t e;
    int sa, sb, r, t;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    if (sub) begin
      e.c = (a >= b) ? 1 : 0;
      t   = (a - b + 16) % 16;
      r   = sa - sb;
    end else begin
      t   = a + b;
      e.c = (t >= 16) ? 1 : 0;
      t   = t % 16;
      r   = sa + sb;
    end
    e.ovf = (r > 7 || r < -8) ? 1 : 0;
    e.acc = t;
`ifdef ADD_SUB_SAT_EN
    if (!sub && e.c == 1) e.acc = 15;
    if (sub && e.c == 0)  e.acc = 0;
`endif
    e.sumf = e.c * 16 + e.acc;
    e.cnt  = (cnt + 1) % 256;
    return e;
  endfunction

  // Predictor: tracks the protocol at each pre-edge sample and pushes expectations.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (rst) begin
      m_acc = 0; m_c = 0; m_sumf = 0; m_ovf = 0; m_cnt = 0;
      busy = 0; age = 0;
      q.delete();
    end else begin
      if (busy) age++;
      chk("out_valid", out_valid, (busy && age >= 2) ? 1 : 0);
      chk("in_ready", in_ready, (!busy && !clear) ? 1 : 0);
      if (!busy) begin
        chk("idle_acc", acc_out, m_acc);
        chk("idle_count", op_count, m_cnt);
        chk("idle_sum_f", sum_f, m_sumf);
        chk("idle_carry", carry_out, m_c);
        chk("idle_ovf", ovf, m_ovf);
      end
      if (busy && age >= 2 && out_ready) begin
        busy = 0;
      end else if (!busy && clear) begin
        m_acc = 0; m_c = 0; m_sumf = 0; m_ovf = 0; m_cnt = 0;
      end else if (!busy && in_valid) begin
        e = predict(m_acc, int'(operand), op_sub, m_cnt);
        q.push_back(e);
        m_acc = e.acc; m_c = e.c; m_sumf = e.sumf; m_ovf = e.ovf; m_cnt = e.cnt;
        busy = 1; age = 0;
      end
    end
  end

  // Monitor: compares every presented result against the queue head; pops on handshake.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = q[0];
        chk("acc_out", acc_out, e.acc);
        chk("carry_out", carry_out, e.c);
        chk("sum_f", sum_f, e.sumf);
        chk("ovf", ovf, e.ovf);
        chk("op_count", op_count, e.cnt);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [3:0] b, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; operand = b; op_sub = s;
    #4;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_clear();
    wait_idle();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_acc"}, acc_out, 0);
    chk({tag, "_sum_f"}, sum_f, 0);
    chk({tag, "_carry"}, carry_out, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_count"}, op_count, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; operand = 4'd0; op_sub = 1'b0;
    clear = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // reset pulse while an operation is in EXEC
    send(4'd4, 1'b0);
    rst = 1'b1;
    #1 chk_all_zero("rst_exec");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", in_ready, 1);

    // add 5, add 7 (signed overflow), add 6 (wrap or saturate)
    send(4'd5, 1'b0);
    send(4'd7, 1'b0);
    send(4'd6, 1'b0);
    // 3 - 5 borrows; 3 - 3 is zero with carry set
    do_clear();
    send(4'd3, 1'b0);
    send(4'd5, 1'b1);
    do_clear();
    send(4'd3, 1'b0);
    send(4'd3, 1'b1);

    // downstream stall with new input offered meanwhile
    wait_idle();
    out_ready = 1'b0;
    send(4'd2, 1'b0);
    in_valid = 1'b1; operand = 4'd9; op_sub = 1'b1;
    repeat (6) @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b0;

    // clear and in_valid together in IDLE
    wait_idle();
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; operand = 4'd4; op_sub = 1'b0;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;

    // 256 operations wrap the counter back to 0
    do_clear();
    for (int i = 0; i < 256; i++) begin
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    wait_idle();

    // randomized traffic including stray clears and backpressure
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      operand   = 4'($urandom_range(0, 15));
      op_sub    = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
